// File: rtl/axil_arbiter_priority_rd_mux.sv
// axil_arbiter_priority_rd_mux: fixed-priority arbiter muxing AXI-Lite read masters onto one slave port
module axil_arbiter_priority_rd_mux #(
  parameter int NUMBER_MASTER   = 4,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,
  input  logic [NUMBER_MASTER*AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  input  logic [NUMBER_MASTER-1:0]                   m_axil_arvalid,
  output logic [NUMBER_MASTER-1:0]                   m_axil_arready,
  output logic [NUMBER_MASTER*AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  output logic [NUMBER_MASTER*2-1:0]                 m_axil_rresp,
  output logic [NUMBER_MASTER-1:0]                   m_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0]                   m_axil_rready,
  output logic [AXIL_ADDR_WIDTH-1:0]                 s_axil_araddr,
  output logic                                       s_axil_arvalid,
  input  logic                                       s_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]                 s_axil_rdata,
  input  logic [1:0]                                 s_axil_rresp,
  input  logic                                       s_axil_rvalid,
  output logic                                       s_axil_rready,
  output logic [NUMBER_MASTER-1:0]                   grant_rd
);
  localparam int IW = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic [IW-1:0] idx, next_idx;
  logic [NUMBER_MASTER-1:0] next_grant;
  always_comb begin
    next_idx   = '0;
    next_grant = '0;
    for (int i = NUMBER_MASTER - 1; i >= 0; i--)
      if (m_axil_arvalid[i]) begin
        next_idx      = IW'(i);
        next_grant    = '0;
        next_grant[i] = 1'b1;
      end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      grant_rd <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: if (|m_axil_arvalid) begin
          grant_rd <= next_grant;
          idx      <= next_idx;
          state    <= ADDR;
        end
        ADDR: if (s_axil_arvalid && s_axil_arready) state <= DATA;
        DATA: if (s_axil_rvalid && s_axil_rready) begin
          grant_rd <= '0;
          idx      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // routing depends only on the registered grant, never on live requests
  always_comb begin
    s_axil_arvalid = (state == ADDR) && m_axil_arvalid[idx];
    s_axil_araddr  = (state == ADDR) ? m_axil_araddr[idx*AXIL_ADDR_WIDTH +: AXIL_ADDR_WIDTH] : '0;
    s_axil_rready  = (state == DATA) && m_axil_rready[idx];
    m_axil_arready = '0;
    m_axil_rvalid  = '0;
    m_axil_rdata   = '0;
    m_axil_rresp   = '0;
    if (state == ADDR) m_axil_arready[idx] = s_axil_arready;
    if (state == DATA) begin
      m_axil_rvalid[idx] = s_axil_rvalid;
      m_axil_rdata[idx*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH] = s_axil_rdata;
      m_axil_rresp[idx*2 +: 2] = s_axil_rresp;
    end
  end
endmodule

// File: tb/tb_axil_arbiter_priority_rd_mux.sv
// tb_axil_arbiter_priority_rd_mux: directed and random checks against a transaction-level model
module tb_axil_arbiter_priority_rd_mux;
  localparam int N = 4, AW = 32, DW = 32;
  logic aclk = 0, aresetn = 0;
  logic [N*AW-1:0] m_axil_araddr = '0;
  logic [N-1:0] m_axil_arvalid = '0, m_axil_arready, m_axil_rvalid, m_axil_rready = '0, grant_rd;
  logic [N*DW-1:0] m_axil_rdata;
  logic [N*2-1:0] m_axil_rresp;
  logic [AW-1:0] s_axil_araddr;
  logic s_axil_arvalid, s_axil_arready = 0, s_axil_rvalid = 0, s_axil_rready;
  logic [DW-1:0] s_axil_rdata = '0;
  logic [1:0] s_axil_rresp = '0;
  int checks = 0, errors = 0, rcount = 0;
  int owner = -1;
  bit in_data = 0;
  logic [N-1:0] hs = '0;

  axil_arbiter_priority_rd_mux #(.NUMBER_MASTER(N), .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready), .grant_rd(grant_rd)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one owner at a time, first in its address phase, then its data phase.
  always @(negedge aclk) begin
    logic [127:0] e_arready, e_rvalid, e_rdata, e_rresp, e_grant, e_araddr;
    logic e_arvalid, e_rready;
    if (!aresetn) begin
      owner = -1;
      in_data = 0;
    end
    e_grant = '0; e_arvalid = 0; e_araddr = '0; e_arready = '0;
    e_rready = 0; e_rvalid = '0; e_rdata = '0; e_rresp = '0;
    if (owner >= 0) begin
      e_grant = 128'(1) << owner;
      if (!in_data) begin
        e_arvalid = m_axil_arvalid[owner];
        e_araddr  = 128'(m_axil_araddr[owner*AW +: AW]);
        e_arready = s_axil_arready ? e_grant : '0;
      end else begin
        e_rready = m_axil_rready[owner];
        e_rvalid = s_axil_rvalid ? e_grant : '0;
        e_rdata  = 128'(s_axil_rdata) << (owner * DW);
        e_rresp  = 128'(s_axil_rresp) << (owner * 2);
      end
    end
    chk("grant_rd", 128'(grant_rd), e_grant);
    chk("s_arvalid", 128'(s_axil_arvalid), 128'(e_arvalid));
    chk("s_araddr", 128'(s_axil_araddr), e_araddr);
    chk("m_arready", 128'(m_axil_arready), e_arready);
    chk("s_rready", 128'(s_axil_rready), 128'(e_rready));
    chk("m_rvalid", 128'(m_axil_rvalid), e_rvalid);
    chk("m_rdata", 128'(m_axil_rdata), e_rdata);
    chk("m_rresp", 128'(m_axil_rresp), e_rresp);
    hs = m_axil_arvalid & m_axil_arready;
    if (s_axil_rvalid && s_axil_rready) rcount++;
    if (aresetn) begin
      if (owner < 0) begin
        for (int i = N - 1; i >= 0; i--) if (m_axil_arvalid[i]) owner = i;
        in_data = 0;
      end else if (!in_data) begin
        if (m_axil_arvalid[owner] && s_axil_arready) in_data = 1;
      end else if (s_axil_rvalid && m_axil_rready[owner]) begin
        owner = -1;
        in_data = 0;
      end
    end
  end

  task automatic tick(); @(posedge aclk); #1; endtask
  task automatic ne(); @(negedge aclk); endtask

  initial begin
    int rc0;
    repeat (3) tick();
    ne();
    chk("rst_grant", 128'(grant_rd), 128'(0));
    chk("rst_rvalid", 128'(m_axil_rvalid), 128'(0));
    aresetn = 1;
    repeat (2) tick();
    ne();
    chk("idle_grant", 128'(grant_rd), 128'(0));
    chk("idle_arready", 128'(m_axil_arready), 128'(0));
    chk("idle_s_arvalid", 128'(s_axil_arvalid), 128'(0));
    // single master 2
    tick();
    m_axil_arvalid = 4'b0100; m_axil_araddr[2*AW +: AW] = 32'h0000_1000;
    s_axil_arready = 1; m_axil_rready = 4'hf;
    ne(); chk("single_pre_grant", 128'(grant_rd), 128'(0));
    tick(); ne();
    chk("single_grant", 128'(grant_rd), 128'(4'b0100));
    chk("single_araddr", 128'(s_axil_araddr), 128'(32'h1000));
    chk("single_arready", 128'(m_axil_arready), 128'(4'b0100));
    tick();
    m_axil_arvalid = '0; s_axil_rvalid = 1; s_axil_rdata = 32'hDEADBEEF; s_axil_rresp = 0;
    ne();
    chk("single_rdata", 128'(m_axil_rdata), 128'hDEADBEEF << 64);
    chk("single_rvalid", 128'(m_axil_rvalid), 128'(4'b0100));
    tick(); s_axil_rvalid = 0;
    ne(); chk("single_done", 128'(grant_rd), 128'(0));
    // contention between 1 and 3
    tick(); m_axil_arvalid = 4'b1010;
    ne(); chk("cont_idle", 128'(grant_rd), 128'(0));
    tick(); ne(); chk("cont_first", 128'(grant_rd), 128'(4'b0010));
    tick(); m_axil_arvalid = 4'b1000; s_axil_rvalid = 1;
    ne(); chk("cont_rvalid", 128'(m_axil_rvalid), 128'(4'b0010));
    tick(); s_axil_rvalid = 0;
    ne(); chk("cont_gap", 128'(grant_rd), 128'(0));
    tick(); ne(); chk("cont_second", 128'(grant_rd), 128'(4'b1000));
    tick(); m_axil_arvalid = '0; s_axil_rvalid = 1;
    tick(); s_axil_rvalid = 0; s_axil_arready = 0;
    // back-pressure with a stray response during ADDR
    m_axil_arvalid = 4'b0001; s_axil_rvalid = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      ne();
      chk("bp_s_arvalid", 128'(s_axil_arvalid), 128'(1));
      chk("stray_rready", 128'(s_axil_rready), 128'(0));
      chk("stray_rvalid", 128'(m_axil_rvalid), 128'(0));
      tick();
    end
    s_axil_arready = 1; rc0 = rcount;
    ne(); chk("bp_arready", 128'(m_axil_arready), 128'(4'b0001));
    tick(); m_axil_arvalid = '0; s_axil_arready = 0; m_axil_rready = '0;
    for (int k = 0; k < 3; k++) begin
      ne();
      chk("bp_rready_hold", 128'(s_axil_rready), 128'(0));
      chk("bp_rvalid_hold", 128'(m_axil_rvalid), 128'(4'b0001));
      tick();
    end
    m_axil_rready = 4'hf;
    ne(); chk("bp_rready", 128'(s_axil_rready), 128'(1));
    tick(); s_axil_rvalid = 0;
    chk("bp_one_xfer", 128'(rcount - rc0), 128'(1));
    ne(); chk("bp_done", 128'(grant_rd), 128'(0));
    // late requests while master 2 is in DATA
    m_axil_arvalid = 4'b0100; s_axil_arready = 1;
    tick(); tick();
    m_axil_arvalid = 4'b1001;
    ne();
    chk("late_hold", 128'(grant_rd), 128'(4'b0100));
    chk("late_no_arready", 128'(m_axil_arready), 128'(0));
    tick(); s_axil_rvalid = 1; s_axil_rdata = 32'h0BADF00D; s_axil_rresp = 2'd2;
    ne(); chk("late_rresp", 128'(m_axil_rresp), 128'(8'h20));
    tick(); s_axil_rvalid = 0;
    ne(); chk("late_gap", 128'(grant_rd), 128'(0));
    tick(); ne(); chk("late_next", 128'(grant_rd), 128'(4'b0001));
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) m_axil_arvalid[i] = 0;
        if (!m_axil_arvalid[i] && $urandom_range(3) == 0) begin
          m_axil_arvalid[i] = 1;
          m_axil_araddr[i*AW +: AW] = $urandom;
        end
      end
      s_axil_arready = 1'($urandom_range(1));
      s_axil_rvalid = 1'($urandom_range(1));
      s_axil_rdata = $urandom;
      s_axil_rresp = 2'($urandom_range(3));
      m_axil_rready = 4'($urandom);
    end
    // async reset in DATA with a response pending
    aresetn = 0; tick(); aresetn = 1;
    m_axil_arvalid = 4'b0010; s_axil_arready = 1; s_axil_rvalid = 0; m_axil_rready = '0;
    tick(); tick();
    m_axil_arvalid = '0; s_axil_rvalid = 1;
    ne(); chk("ar_pending", 128'(m_axil_rvalid), 128'(4'b0010));
    #2 aresetn = 0;
    #1;
    chk("ar_rvalid", 128'(m_axil_rvalid), 128'(0));
    chk("ar_grant", 128'(grant_rd), 128'(0));
    chk("ar_rdata", 128'(m_axil_rdata), 128'(0));
    tick(); tick(); aresetn = 1; s_axil_rvalid = 0;
    ne(); chk("ar_idle", 128'(grant_rd), 128'(0));
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_arbiter_priority_rd_mux.md
Name: axil_arbiter_priority_rd_mux

Overview:
- Read-direction counterpart of the interconnect's priority write arbiter.
- Arbitrates NUMBER_MASTER AXI-Lite read masters onto one shared slave read port (AR + R channels) using fixed priority; index 0 is highest.
- Holds the grant for one complete read transaction: AR handshake followed by R handshake.
- Routes AR forward and R back to the granted master only.

Parameters:
NUMBER_MASTER, 4, number of upstream read masters (>=2)
AXIL_ADDR_WIDTH, 32, address width
AXIL_DATA_WIDTH, 32, data width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
m_axil_araddr  in  NUMBER_MASTER*AXIL_ADDR_WIDTH  per-master read address, master i at slice i
m_axil_arvalid  in  NUMBER_MASTER  per-master AR valid (arbitration request)
m_axil_arready  out  NUMBER_MASTER  per-master AR ready
m_axil_rdata  out  NUMBER_MASTER*AXIL_DATA_WIDTH  per-master read data
m_axil_rresp  out  NUMBER_MASTER*2  per-master read response
m_axil_rvalid  out  NUMBER_MASTER  per-master R valid
m_axil_rready  in  NUMBER_MASTER  per-master R ready
s_axil_araddr  out  AXIL_ADDR_WIDTH  shared slave read address
s_axil_arvalid  out  1  shared slave AR valid
s_axil_arready  in  1  shared slave AR ready
s_axil_rdata  in  AXIL_DATA_WIDTH  shared slave read data
s_axil_rresp  in  2  shared slave read response
s_axil_rvalid  in  1  shared slave R valid
s_axil_rready  out  1  shared slave R ready
grant_rd  out  NUMBER_MASTER  one-hot current grant, 0 when idle

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE, grant_rd=0, internal grant index=0.
  - All outputs 0: m_axil_arready, m_axil_rvalid, m_axil_rdata, m_axil_rresp, s_axil_arvalid, s_axil_araddr, s_axil_rready.
  - Reset mid-transaction abandons it immediately; no recovery or replay.
- FSM, three states:
  - IDLE: if any m_axil_arvalid=1, register grant_rd = lowest set index (one-hot) plus its binary index, then go to ADDR. Otherwise stay in IDLE.
  - ADDR: s_axil_arvalid = m_axil_arvalid[g]; s_axil_araddr = slice g; m_axil_arready[g] = s_axil_arready. On s_axil_arvalid && s_axil_arready, go to DATA.
  - DATA: m_axil_rvalid[g] = s_axil_rvalid; rdata/rresp slice g = slave values; s_axil_rready = m_axil_rready[g]. On s_axil_rvalid && s_axil_rready, go to IDLE and clear grant_rd and the index in the same edge.
- Routing:
  - Channel routing is combinational from the registered grant. There is no path from any m_axil_arvalid to m_axil_arready while in IDLE.
  - Non-granted masters always see arready=0, rvalid=0, rdata=0, rresp=0.
  - The slave sees arvalid=0 outside ADDR and rready=0 outside DATA. An s_axil_rvalid arriving during IDLE or ADDR is not accepted.
- Latency:
  - Grant appears 1 cycle after a request is seen in IDLE.
  - Minimum transaction is 3 cycles (IDLE→ADDR→DATA→IDLE) when the slave is zero-wait.
  - Next arbitration happens in the IDLE cycle after R completes.
- Priority:
  - Simultaneous requests: lowest index wins.
  - Requests arriving while ADDR or DATA is active are ignored until IDLE.
  - Starvation of high indices under continuous low-index traffic is accepted by design.
- Protocol violation: if the granted master drops arvalid in ADDR, the block stays in ADDR and forwards arvalid=0. It does not re-arbitrate.

Test Plan:
- Reset/idle: hold aresetn=0, then release with no requests. Required: grant_rd=0, all ready/valid outputs 0. Assert aresetn in DATA with rvalid pending; outputs must drop to 0 without waiting for a clock edge.
- Single master: master 2 reads 0x0000_1000; slave arready=1, then rvalid=1, rdata=0xDEADBEEF, rresp=0. Required:
  - grant_rd=4'b0100 one cycle after arvalid.
  - s_axil_araddr=0x1000.
  - m_axil_rdata slice 2 = 0xDEADBEEF; other slices 0.
  - grant_rd=0 after the R handshake.
- Contention: masters 1 and 3 request in the same cycle. Required: master 1 is served first (grant 4'b0010); master 3 is granted 4'b1000 on the cycle after the IDLE following completion.
- Back-pressure: slave holds arready=0 for 5 cycles, then rvalid=1 while m_axil_rready[g]=0 for 3 cycles. Required: stays in ADDR for 5 cycles with s_axil_arvalid held at 1; R is held with s_axil_rready=0 for 3 cycles; exactly one transfer completes.
- Late request: master 0 raises arvalid while master 2 is in DATA. Required: master 2 completes undisturbed; master 0 is granted next, even if master 3 also requests then.
- Stray response: slave asserts rvalid during ADDR. Required: s_axil_rready=0 and no m_axil_rvalid is asserted.
